// File: rtl/udp_reg_cmd_decoder_if.sv
// UDP receive payload stream into the register command decoder.
// Valid-only stream: a byte transfers on every rgmii_clk edge with udp_rec_data_valid=1;
// there is no ready, the decoder accepts every byte it is offered.
interface udp_reg_cmd_decoder_if;
  logic        udp_rec_data_valid;
  logic [7:0]  udp_rec_rdata;
  logic [15:0] udp_rec_data_length;

  modport master (output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length);
  modport slave  (input  udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length);
endinterface

// File: rtl/udp_reg_cmd_decoder.sv
// Decodes MAGIC-prefixed UDP payloads of (address, data) records into register bank writes,
// keeps good/bad packet counters and drives activity and heartbeat LEDs.
module udp_reg_cmd_decoder #(
  parameter int          N_REGS        = 16,
  parameter int          DATA_W        = 32,
  parameter logic [7:0]  MAGIC         = 8'hA5,
  parameter logic [23:0] LED_HOLD      = 24'd6_250_000,
  parameter logic [31:0] HEARTBEAT_CYC = 32'h1_FFF_FFF
) (
  input  logic                     rgmii_clk,
  input  logic                     rstn,
  udp_reg_cmd_decoder_if.slave     rx,
  output logic                     reg_wr_en,
  output logic [7:0]               reg_wr_addr,
  output logic [DATA_W-1:0]        reg_wr_data,
  output logic [N_REGS*DATA_W-1:0] reg_bank,
  output logic [15:0]              pkt_ok_cnt,
  output logic [15:0]              pkt_err_cnt,
  output logic                     led_act,
  output logic                     led_hb,
  output logic [1:0]               fsm_state
);
  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DROP = 2'd3} state_t;
  state_t state, state_nxt;

  logic              valid;
  logic [7:0]        rdata;
  logic              addr_in_range;
  logic              last_byte;
  logic              pkt_end;
  logic [DATA_W-1:0] data_nxt;

  logic [15:0]       byte_cnt, len_q;
  logic [3:0]        dcnt;
  logic [7:0]        addr_q;
  logic              addr_ok, err_q, rec_seen, silent_q, resync_q;
  logic [DATA_W-1:0] shift_q;
  logic              wr_pend, end_pend, end_bad;
  logic [7:0]        pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic [23:0]       act_timer;
  logic [31:0]       hb_cnt;

  assign valid         = rx.udp_rec_data_valid;
  assign rdata         = rx.udp_rec_rdata;
  assign addr_in_range = ({1'b0, rdata} < 9'(N_REGS));
  assign last_byte     = (dcnt == 4'(NB - 1));
  assign pkt_end       = (state != IDLE) && !valid;
  assign data_nxt      = (shift_q << 8) | DATA_W'(rdata);
  assign led_act       = |act_timer;
  assign fsm_state     = state;

  always_ff @(posedge rgmii_clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // resync_q marks bytes left over from a packet cut by reset; they are dropped silently
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (valid) state_nxt = (resync_q || rdata != MAGIC) ? DROP : ADDR;
      ADDR: state_nxt = valid ? DATA : IDLE;
      DATA: if (!valid)        state_nxt = IDLE;
            else if (last_byte) state_nxt = ADDR;
      DROP: if (!valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      byte_cnt    <= '0;
      len_q       <= '0;
      dcnt        <= '0;
      addr_q      <= '0;
      addr_ok     <= 1'b0;
      err_q       <= 1'b0;
      rec_seen    <= 1'b0;
      silent_q    <= 1'b0;
      resync_q    <= 1'b1;
      shift_q     <= '0;
      wr_pend     <= 1'b0;
      end_pend    <= 1'b0;
      end_bad     <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      reg_bank    <= '0;
      pkt_ok_cnt  <= '0;
      pkt_err_cnt <= '0;
      act_timer   <= '0;
      hb_cnt      <= '0;
      led_hb      <= 1'b0;
    end else begin
      wr_pend   <= 1'b0;
      end_pend  <= 1'b0;
      reg_wr_en <= wr_pend;
      if (wr_pend) begin
        reg_wr_addr <= pend_addr;
        reg_wr_data <= pend_data;
        for (int r = 0; r < N_REGS; r++)
          if (pend_addr == 8'(r)) reg_bank[r*DATA_W +: DATA_W] <= pend_data;
      end

      if (end_pend && end_bad) begin
        pkt_err_cnt <= pkt_err_cnt + 16'd1;
        if (act_timer != '0) act_timer <= act_timer - 24'd1;
      end else if (end_pend) begin
        pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
        act_timer  <= LED_HOLD;
      end else if (act_timer != '0) begin
        act_timer <= act_timer - 24'd1;
      end

      if (hb_cnt == HEARTBEAT_CYC) begin
        hb_cnt <= '0;
        led_hb <= ~led_hb;
      end else begin
        hb_cnt <= hb_cnt + 32'd1;
      end

      case (state)
        IDLE: begin
          if (valid) begin
            len_q    <= rx.udp_rec_data_length;
            byte_cnt <= 16'd1;
            rec_seen <= 1'b0;
            silent_q <= resync_q;
            err_q    <= (rdata != MAGIC);
          end
          resync_q <= 1'b0;
        end
        ADDR: if (valid) begin
          byte_cnt <= byte_cnt + 16'd1;
          addr_q   <= rdata;
          addr_ok  <= addr_in_range;
          dcnt     <= '0;
          if (!addr_in_range) err_q <= 1'b1;
        end
        DATA: if (valid) begin
          byte_cnt <= byte_cnt + 16'd1;
          shift_q  <= data_nxt;
          dcnt     <= dcnt + 4'd1;
          if (last_byte) begin
            rec_seen <= 1'b1;
            if (addr_ok) begin
              wr_pend   <= 1'b1;
              pend_addr <= addr_q;
              pend_data <= data_nxt;
            end
          end
        end
        DROP: if (valid) byte_cnt <= byte_cnt + 16'd1;
        default: ;
      endcase

      // Verdict is taken on the valid=0 cycle and applied to the counters one edge later
      if (pkt_end && !silent_q) begin
        end_pend <= 1'b1;
        end_bad  <= err_q || (state == DATA) || (byte_cnt != len_q) || !rec_seen;
      end
    end
  end
endmodule

// File: tb/tb_udp_reg_cmd_decoder.sv
// Bench for udp_reg_cmd_decoder: packet driver, write scoreboard with cycle-exact latency,
// counter/bank/LED checks per scenario.
module tb_udp_reg_cmd_decoder;
  localparam int          N_REGS   = 16;
  localparam int          DATA_W   = 32;
  localparam logic [23:0] LED_HOLD = 24'd40;
  localparam logic [31:0] HB_CYC   = 32'd9;
  localparam int          W        = 32 + 8 + DATA_W;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  udp_reg_cmd_decoder_if rx();

  logic                     reg_wr_en;
  logic [7:0]               reg_wr_addr;
  logic [DATA_W-1:0]        reg_wr_data;
  logic [N_REGS*DATA_W-1:0] reg_bank;
  logic [15:0]              pkt_ok_cnt, pkt_err_cnt;
  logic                     led_act, led_hb;
  logic [1:0]               fsm_state;

  udp_reg_cmd_decoder #(
    .N_REGS(N_REGS), .DATA_W(DATA_W), .MAGIC(8'hA5),
    .LED_HOLD(LED_HOLD), .HEARTBEAT_CYC(HB_CYC)
  ) dut (
    .rgmii_clk(clk), .rstn(rstn), .rx(rx),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_bank(reg_bank), .pkt_ok_cnt(pkt_ok_cnt), .pkt_err_cnt(pkt_err_cnt),
    .led_act(led_act), .led_hb(led_hb), .fsm_state(fsm_state)
  );

  typedef struct {
    int          idx;
    logic [7:0]  addr;
    logic [31:0] data;
  } plan_t;

  int                       checks = 0;
  int                       errors = 0;
  logic [31:0]              cyc = 0;
  logic [W-1:0]             exp_q[$];
  plan_t                    plan_q[$];
  logic [7:0]               pkt_q[$];
  logic [N_REGS*DATA_W-1:0] exp_bank = '0;
  logic [15:0]              exp_ok = 0, exp_err = 0;
  logic [31:0]              end_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must match the next expected {cycle, addr, data}
  always @(negedge clk) begin
    if (reg_wr_en) begin
      logic [W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h at cycle %0d, required no write",
                 reg_wr_addr, reg_wr_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({cyc, reg_wr_addr, reg_wr_data} !== e) begin
          errors++;
          $display("FAIL write: got cyc %0d addr %0h data %0h, required cyc %0d addr %0h data %0h",
                   cyc, reg_wr_addr, reg_wr_data, e[W-1 -: 32], e[DATA_W +: 8], e[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic add_rec(input int idx, input logic [7:0] a, input logic [31:0] d);
    plan_t p;
    p.idx = idx; p.addr = a; p.data = d;
    plan_q.push_back(p);
  endtask

  // Drives pkt_q as one packet then a single valid=0 cycle; end_cyc = cycle of that low cycle
  task automatic send_pkt(input logic [15:0] len);
    for (int i = 0; i < pkt_q.size(); i++) begin
      @(posedge clk); #1;
      rx.udp_rec_data_valid  = 1'b1;
      rx.udp_rec_rdata       = pkt_q[i];
      rx.udp_rec_data_length = (i == 0) ? len : 16'($urandom_range(0, 65535));
      if (plan_q.size() > 0 && plan_q[0].idx == i) begin
        plan_t p = plan_q.pop_front();
        exp_q.push_back({cyc + 32'd2, p.addr, p.data});
        exp_bank[p.addr*DATA_W +: DATA_W] = p.data;
      end
    end
    @(posedge clk); #1;
    rx.udp_rec_data_valid = 1'b0;
    rx.udp_rec_rdata      = 8'($urandom_range(0, 255));
    end_cyc = cyc;
    pkt_q.delete();
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rx.udp_rec_data_valid  = 1'b0;
    rx.udp_rec_rdata       = 8'h00;
    rx.udp_rec_data_length = 16'h0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b required 0", reg_wr_en); end
    checks++; if (reg_wr_addr !== 8'h0) begin errors++; $display("FAIL rst_wr_addr: got %0h required 0", reg_wr_addr); end
    checks++; if (reg_wr_data !== '0) begin errors++; $display("FAIL rst_wr_data: got %0h required 0", reg_wr_data); end
    checks++; if (reg_bank !== '0) begin errors++; $display("FAIL rst_bank: got %0h required 0", reg_bank); end
    checks++; if (pkt_ok_cnt !== 16'h0) begin errors++; $display("FAIL rst_ok_cnt: got %0d required 0", pkt_ok_cnt); end
    checks++; if (pkt_err_cnt !== 16'h0) begin errors++; $display("FAIL rst_err_cnt: got %0d required 0", pkt_err_cnt); end
    checks++; if (led_act !== 1'b0) begin errors++; $display("FAIL rst_led_act: got %b required 0", led_act); end
    checks++; if (led_hb !== 1'b0) begin errors++; $display("FAIL rst_led_hb: got %b required 0", led_hb); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d required 0", fsm_state); end
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_write();
    pkt_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    add_rec(5, 8'h03, 32'h11223344);
    send_pkt(16'd6);
    @(negedge clk);
    @(negedge clk);
    checks++; if (pkt_ok_cnt !== exp_ok) begin errors++; $display("FAIL ok_cnt_early: got %0d required %0d", pkt_ok_cnt, exp_ok); end
    exp_ok++;
    @(negedge clk);
    checks++; if (pkt_ok_cnt !== exp_ok) begin errors++; $display("FAIL ok_cnt_single: got %0d required %0d", pkt_ok_cnt, exp_ok); end
    checks++; if (led_act !== 1'b1) begin errors++; $display("FAIL led_act_on: got %b required 1", led_act); end
    settle();
    checks++; if (reg_bank !== exp_bank) begin errors++; $display("FAIL bank_single: got %0h required %0h", reg_bank, exp_bank); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL missing_write_single: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_multi_record();
    pkt_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h0F, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    add_rec(5, 8'h00, 32'h00000001);
    add_rec(10, 8'h0F, 32'hDEADBEEF);
    send_pkt(16'd11);
    exp_ok++;
    settle();
    checks++; if (pkt_ok_cnt !== exp_ok) begin errors++; $display("FAIL ok_cnt_multi: got %0d required %0d", pkt_ok_cnt, exp_ok); end
    checks++; if (reg_bank !== exp_bank) begin errors++; $display("FAIL bank_multi: got %0h required %0h", reg_bank, exp_bank); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL missing_write_multi: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_bad_magic();
    pkt_q = '{8'h5A, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_pkt(16'd6);
    exp_err++;
    settle();
    checks++; if (pkt_err_cnt !== exp_err) begin errors++; $display("FAIL err_cnt_magic: got %0d required %0d", pkt_err_cnt, exp_err); end
    checks++; if (pkt_ok_cnt !== exp_ok) begin errors++; $display("FAIL ok_cnt_magic: got %0d required %0d", pkt_ok_cnt, exp_ok); end
    checks++; if (reg_bank !== exp_bank) begin errors++; $display("FAIL bank_magic: got %0h required %0h", reg_bank, exp_bank); end
  endtask

  task automatic test_bad_addr_trunc();
    pkt_q = '{8'hA5, 8'h20, 8'h00, 8'h00, 8'h00, 8'h07};
    send_pkt(16'd6);
    exp_err++;
    settle();
    checks++; if (pkt_err_cnt !== exp_err) begin errors++; $display("FAIL err_cnt_addr: got %0d required %0d", pkt_err_cnt, exp_err); end
    pkt_q = '{8'hA5, 8'h02, 8'h12, 8'h34};
    send_pkt(16'd4);
    exp_err++;
    settle();
    checks++; if (pkt_err_cnt !== exp_err) begin errors++; $display("FAIL err_cnt_trunc: got %0d required %0d", pkt_err_cnt, exp_err); end
    checks++; if (pkt_ok_cnt !== exp_ok) begin errors++; $display("FAIL ok_cnt_trunc: got %0d required %0d", pkt_ok_cnt, exp_ok); end
    checks++; if (reg_bank !== exp_bank) begin errors++; $display("FAIL bank_trunc: got %0h required %0h", reg_bank, exp_bank); end
  endtask

  task automatic test_len_mismatch();
    pkt_q = '{8'hA5, 8'h07, 8'h55, 8'h66, 8'h77, 8'h88};
    add_rec(5, 8'h07, 32'h55667788);
    send_pkt(16'd9);
    exp_err++;
    settle();
    checks++; if (pkt_err_cnt !== exp_err) begin errors++; $display("FAIL err_cnt_len: got %0d required %0d", pkt_err_cnt, exp_err); end
    checks++; if (pkt_ok_cnt !== exp_ok) begin errors++; $display("FAIL ok_cnt_len: got %0d required %0d", pkt_ok_cnt, exp_ok); end
    checks++; if (reg_bank !== exp_bank) begin errors++; $display("FAIL bank_len: got %0h required %0h", reg_bank, exp_bank); end
  endtask

  task automatic test_zero_records();
    pkt_q = '{8'hA5};
    send_pkt(16'd1);
    exp_err++;
    settle();
    checks++; if (pkt_err_cnt !== exp_err) begin errors++; $display("FAIL err_cnt_zero: got %0d required %0d", pkt_err_cnt, exp_err); end
    checks++; if (pkt_ok_cnt !== exp_ok) begin errors++; $display("FAIL ok_cnt_zero: got %0d required %0d", pkt_ok_cnt, exp_ok); end
  endtask

  task automatic test_back_to_back();
    pkt_q = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    add_rec(5, 8'h04, 32'h01020304);
    send_pkt(16'd6);
    pkt_q = '{8'hA5, 8'h05, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    add_rec(5, 8'h05, 32'h0A0B0C0D);
    send_pkt(16'd6);
    exp_ok += 2;
    settle();
    checks++; if (pkt_ok_cnt !== exp_ok) begin errors++; $display("FAIL ok_cnt_b2b: got %0d required %0d", pkt_ok_cnt, exp_ok); end
    checks++; if (reg_bank !== exp_bank) begin errors++; $display("FAIL bank_b2b: got %0h required %0h", reg_bank, exp_bank); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL missing_write_b2b: got %0d pending required 0", exp_q.size()); end
  endtask

  // Reset lands on a data byte; the tail contains a well-formed record that must be ignored
  task automatic test_reset_mid_packet();
    logic [7:0] tail[$];
    tail = '{8'h44, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h09};
    pkt_q = '{8'hA5, 8'h02, 8'h11, 8'h22};
    for (int i = 0; i < pkt_q.size(); i++) begin
      @(posedge clk); #1;
      rx.udp_rec_data_valid = 1'b1;
      rx.udp_rec_rdata      = pkt_q[i];
      rx.udp_rec_data_length = (i == 0) ? 16'd6 : 16'd0;
    end
    pkt_q.delete();
    @(posedge clk); #1;
    rx.udp_rec_rdata = 8'h33;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    rstn = 1'b1;
    exp_ok = 0; exp_err = 0; exp_bank = '0;
    @(negedge clk);
    checks++; if (reg_bank !== '0) begin errors++; $display("FAIL midrst_bank: got %0h required 0", reg_bank); end
    checks++; if (reg_wr_addr !== 8'h0 || reg_wr_data !== '0) begin errors++; $display("FAIL midrst_wr: got %0h/%0h required 0/0", reg_wr_addr, reg_wr_data); end
    checks++; if (pkt_ok_cnt !== 16'h0 || pkt_err_cnt !== 16'h0) begin errors++; $display("FAIL midrst_cnt: got %0d/%0d required 0/0", pkt_ok_cnt, pkt_err_cnt); end
    checks++; if (led_act !== 1'b0 || led_hb !== 1'b0) begin errors++; $display("FAIL midrst_led: got %b/%b required 0/0", led_act, led_hb); end
    for (int i = 0; i < tail.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      rx.udp_rec_data_valid = 1'b1;
      rx.udp_rec_rdata      = tail[i];
      rx.udp_rec_data_length = 16'd6;
    end
    @(posedge clk); #1;
    rx.udp_rec_data_valid = 1'b0;
    settle();
    checks++; if (pkt_ok_cnt !== exp_ok || pkt_err_cnt !== exp_err) begin errors++; $display("FAIL midrst_tail_cnt: got %0d/%0d required %0d/%0d", pkt_ok_cnt, pkt_err_cnt, exp_ok, exp_err); end
    checks++; if (reg_bank !== exp_bank) begin errors++; $display("FAIL midrst_tail_bank: got %0h required %0h", reg_bank, exp_bank); end
    pkt_q = '{8'hA5, 8'h06, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    add_rec(5, 8'h06, 32'hCAFEF00D);
    send_pkt(16'd6);
    exp_ok++;
    settle();
    checks++; if (pkt_ok_cnt !== exp_ok) begin errors++; $display("FAIL midrst_next_ok: got %0d required %0d", pkt_ok_cnt, exp_ok); end
    checks++; if (reg_bank !== exp_bank) begin errors++; $display("FAIL midrst_next_bank: got %0h required %0h", reg_bank, exp_bank); end
  endtask

  task automatic test_led();
    int hi = 0;
    bit seen = 0;
    for (int n = 0; n < 200 && led_act; n++) @(negedge clk);
    pkt_q = '{8'hA5, 8'h09, 8'h01, 8'h23, 8'h45, 8'h67};
    add_rec(5, 8'h09, 32'h01234567);
    send_pkt(16'd6);
    exp_ok++;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (led_act) begin seen = 1; hi++; end
      else if (seen) break;
    end
    checks++; if (hi != int'(LED_HOLD)) begin errors++; $display("FAIL led_act_hold: got %0d cycles required %0d", hi, LED_HOLD); end
    checks++; if (pkt_ok_cnt !== exp_ok) begin errors++; $display("FAIL ok_cnt_led: got %0d required %0d", pkt_ok_cnt, exp_ok); end
  endtask

  task automatic test_heartbeat();
    logic prev;
    bit   found = 0;
    int   n2 = 0;
    prev = led_hb;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (led_hb !== prev) begin found = 1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL hb_toggle: got no toggle in 40 cycles required a toggle"); end
    prev = led_hb;
    found = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      n2++;
      if (led_hb !== prev) begin found = 1; break; end
    end
    checks++; if (!found || n2 != int'(HB_CYC) + 1) begin errors++; $display("FAIL hb_period: got %0d cycles required %0d", n2, HB_CYC + 1); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_multi_record();
    test_bad_magic();
    test_bad_addr_trunc();
    test_len_mismatch();
    test_zero_records();
    test_back_to_back();
    test_reset_mid_packet();
    test_led();
    test_heartbeat();
    settle();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL writes_outstanding: got %0d pending required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
